ram4k_arbiter: RTL and testbench

Arbitrated access controller for one `ram4k` instance (4096 x 16, combinational read, write on rising `clk` when `load`=1). Two independent requesters share the memory through a req/ack handshake, with round-robin fairness. A built-in clear engine zero-fills the whole array on command. The block drives the RAM's `address`/`in`/`load` ports and samples its `out` port; it sits between the RAM4K and the CPU/DMA-side masters.

---
 rtl/ram4k_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram4k_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram4k_arbiter.sv
// Round-robin req/ack arbiter in front of a single-port RAM4K, with a zero-fill clear engine.
// Every output comes straight from a register, so no input reaches an output combinationally.
module ram4k_arbiter #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          ack0_o,
    output logic          ack1_o,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o,
    input  logic          clr_start_i,
    output logic          clr_busy_o,
    output logic [AW-1:0] mem_address_o,
    output logic [DW-1:0] mem_in_o,
    output logic          mem_load_o,
    input  logic [DW-1:0] mem_out_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StClear} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          id_q, id_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          load_q, load_d;
    logic          busy_q, busy_d;

    logic elig0, elig1, grant1;

    // A requester in its own ack cycle is masked so it cannot be re-granted on a stale req.
    assign elig0  = req0_i & ~ack0_q;
    assign elig1  = req1_i & ~ack1_q;
    assign grant1 = elig1 & (~elig0 | ~last_q);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        load_d   = load_q;
        busy_d   = busy_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start_i) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                end else if (elig0 || elig1) begin
                    state_d = StAccess;
                    id_d    = grant1;
                    last_d  = grant1;
                    addr_d  = grant1 ? addr1_i  : addr0_i;
                    wdata_d = grant1 ? wdata1_i : wdata0_i;
                    load_d  = grant1 ? we1_i    : we0_i;
                end
            end
            StAccess: begin
                state_d = StIdle;
                load_d  = 1'b0;
                if (id_q) begin
                    ack1_d = 1'b1;
                    if (!load_q) rdata1_d = mem_out_i;
                end else begin
                    ack0_d = 1'b1;
                    if (!load_q) rdata0_d = mem_out_i;
                end
            end
            StClear: begin
                if (cnt_q == '1) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    load_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q + AW'(1);
                    addr_d = cnt_q + AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            cnt_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            load_q   <= load_d;
            busy_q   <= busy_d;
        end
    end

    assign ack0_o        = ack0_q;
    assign ack1_o        = ack1_q;
    assign rdata0_o      = rdata0_q;
    assign rdata1_o      = rdata1_q;
    assign clr_busy_o    = busy_q;
    assign mem_address_o = addr_q;
    assign mem_in_o      = wdata_q;
    assign mem_load_o    = load_q;

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Bench for ram4k_arbiter: behavioural RAM4K, per-cycle vector table, then clear/reset sequences.
module tb_ram4k_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [11:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        clr_start, clr_busy;
    logic [11:0] mem_address;
    logic [15:0] mem_in, mem_out;
    logic        mem_load;

    logic [15:0] mem [4096];
    logic        preload_en;
    logic [11:0] pidx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Behavioural RAM4K; the preload port stamps each word with {4'hC, address}.
    always @(posedge clk) begin
        if (preload_en) mem[pidx] <= {4'hC, pidx};
        else if (mem_load) mem[mem_address] <= mem_in;
    end
    assign mem_out = mem[mem_address];

    ram4k_arbiter #(.AW(12), .DW(16)) dut (
        .clk_i(clk), .reset_i(reset),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
        .clr_start_i(clr_start), .clr_busy_o(clr_busy),
        .mem_address_o(mem_address), .mem_in_o(mem_in), .mem_load_o(mem_load),
        .mem_out_i(mem_out)
    );

    typedef struct {
        logic        r0, w0;
        logic [11:0] a0;
        logic [15:0] d0;
        logic        r1, w1;
        logic [11:0] a1;
        logic [15:0] d1;
        logic        k0, k1, ld;
        logic [11:0] ma;
        logic [15:0] q0, q1;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic r0, input logic w0, input logic [11:0] a0,
                                input logic [15:0] d0, input logic r1, input logic w1,
                                input logic [11:0] a1, input logic [15:0] d1,
                                input logic k0, input logic k1, input logic ld,
                                input logic [11:0] ma, input logic [15:0] q0,
                                input logic [15:0] q1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.k0 = k0; v.k1 = k1; v.ld = ld; v.ma = ma; v.q0 = q0; v.q1 = q1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One requester-0 transaction; waits a bounded number of cycles for ack0.
    task automatic access0(input logic we, input logic [11:0] a, input logic [15:0] d,
                           output logic [15:0] rd);
        logic seen;
        seen = 1'b0;
        req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (ack0) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("access0 ack addr %h", a), 32'(seen), 32'd1);
        req0 = 1'b0; we0 = 1'b0;
        rd = rdata0;
    endtask

    initial begin
        logic [15:0] rd, v;
        logic [15:0] rnd [4];
        logic [11:0] fill [4];
        int          busy_cycles, lat;
        logic        early_ack, seen;

        reset = 1'b1; clr_start = 1'b0; preload_en = 1'b1; pidx = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        #1;
        for (int i = 0; i < 4096; i++) begin
            pidx = 12'(i);
            tick();
        end
        preload_en = 1'b0;

        chk("reset ack0", 32'(ack0), 32'd0);
        chk("reset ack1", 32'(ack1), 32'd0);
        chk("reset rdata0", 32'(rdata0), 32'd0);
        chk("reset mem_load", 32'(mem_load), 32'd0);
        chk("reset mem_address", 32'(mem_address), 32'd0);
        chk("reset clr_busy", 32'(clr_busy), 32'd0);
        tick();
        reset = 1'b0;

        // r0 w0 a0 d0 | r1 w1 a1 d1 | ack0 ack1 load addr rdata0 rdata1 (after the edge)
        tbl[0]  = mk(1'b1, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'hFFF, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h0000);
        tbl[1]  = mk(1'b1, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'hFFF, 16'h0000,
                     1'b1, 1'b0, 1'b0, 12'h000, 16'hC000, 16'h0000);
        tbl[2]  = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'hFFF, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'hFFF, 16'hC000, 16'h0000);
        tbl[3]  = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'hFFF, 16'h0000,
                     1'b0, 1'b1, 1'b0, 12'hFFF, 16'hC000, 16'hCFFF);
        tbl[4]  = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'hFFF, 16'hC000, 16'hCFFF);
        tbl[5]  = mk(1'b1, 1'b1, 12'h003, 16'hBEEF, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 1'b1, 12'h003, 16'hC000, 16'hCFFF);
        tbl[6]  = mk(1'b1, 1'b1, 12'h003, 16'hBEEF, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b1, 1'b0, 1'b0, 12'h003, 16'hC000, 16'hCFFF);
        tbl[7]  = mk(1'b1, 1'b0, 12'h003, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'h003, 16'hC000, 16'hCFFF);
        tbl[8]  = mk(1'b1, 1'b0, 12'h003, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'h003, 16'hC000, 16'hCFFF);
        tbl[9]  = mk(1'b1, 1'b0, 12'h003, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b1, 1'b0, 1'b0, 12'h003, 16'hBEEF, 16'hCFFF);
        tbl[10] = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'h003, 16'hBEEF, 16'hCFFF);
        tbl[11] = mk(1'b1, 1'b0, 12'h003, 16'h0000, 1'b1, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'h000, 16'hBEEF, 16'hCFFF);
        tbl[12] = mk(1'b1, 1'b0, 12'h003, 16'h0000, 1'b1, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b1, 1'b0, 12'h000, 16'hBEEF, 16'hC000);
        tbl[13] = mk(1'b1, 1'b0, 12'h003, 16'h0000, 1'b1, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'h003, 16'hBEEF, 16'hC000);
        tbl[14] = mk(1'b1, 1'b0, 12'h003, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b1, 1'b0, 1'b0, 12'h003, 16'hBEEF, 16'hC000);
        tbl[15] = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'h003, 16'hBEEF, 16'hC000);
        tbl[16] = mk(1'b1, 1'b0, 12'h007, 16'h0000, 1'b1, 1'b1, 12'h007, 16'h1234,
                     1'b0, 1'b0, 1'b1, 12'h007, 16'hBEEF, 16'hC000);
        tbl[17] = mk(1'b1, 1'b0, 12'h007, 16'h0000, 1'b1, 1'b1, 12'h007, 16'h1234,
                     1'b0, 1'b1, 1'b0, 12'h007, 16'hBEEF, 16'hC000);
        tbl[18] = mk(1'b1, 1'b0, 12'h007, 16'h0000, 1'b1, 1'b0, 12'h007, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'h007, 16'hBEEF, 16'hC000);
        tbl[19] = mk(1'b1, 1'b0, 12'h007, 16'h0000, 1'b1, 1'b0, 12'h007, 16'h0000,
                     1'b1, 1'b0, 1'b0, 12'h007, 16'h1234, 16'hC000);
        tbl[20] = mk(1'b1, 1'b0, 12'h007, 16'h0000, 1'b1, 1'b0, 12'h007, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'h007, 16'h1234, 16'hC000);
        tbl[21] = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h007, 16'h0000,
                     1'b0, 1'b1, 1'b0, 12'h007, 16'h1234, 16'h1234);
        tbl[22] = mk(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000,
                     1'b0, 1'b0, 1'b0, 12'h007, 16'h1234, 16'h1234);

        for (int i = 0; i < 23; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
            tick();
            chk($sformatf("vec%0d ack0", i), 32'(ack0), 32'(tbl[i].k0));
            chk($sformatf("vec%0d ack1", i), 32'(ack1), 32'(tbl[i].k1));
            chk($sformatf("vec%0d mem_load", i), 32'(mem_load), 32'(tbl[i].ld));
            chk($sformatf("vec%0d mem_address", i), 32'(mem_address), 32'(tbl[i].ma));
            chk($sformatf("vec%0d rdata0", i), 32'(rdata0), 32'(tbl[i].q0));
            chk($sformatf("vec%0d rdata1", i), 32'(rdata1), 32'(tbl[i].q1));
        end

        // Single requester held high: one grant every 3 cycles.
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h005;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("b2b ack0 cyc%0d", i), 32'(ack0), 32'((i % 3) == 1));
            chk($sformatf("b2b ack1 cyc%0d", i), 32'(ack1), 32'd0);
        end
        req0 = 1'b0;
        chk("b2b rdata0", 32'(rdata0), 32'h0000C005);

        // Fill, clear, confirm zeroed and that a request during the clear waits.
        fill[0] = 12'h000; fill[1] = 12'h003; fill[2] = 12'h007; fill[3] = 12'hFFF;
        for (int i = 0; i < 4; i++) begin
            rnd[i] = 16'($urandom) | 16'h0001;
            access0(1'b1, fill[i], rnd[i], rd);
        end
        access0(1'b0, 12'hFFF, 16'h0000, rd);
        chk("prefill read 4095", 32'(rd), 32'(rnd[3]));

        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("clr_busy rise", 32'(clr_busy), 32'd1);
        busy_cycles = 1;
        early_ack = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if (c == 50) begin
                req0 = 1'b1; we0 = 1'b0; addr0 = 12'hFFF;
            end
            tick();
            if (ack0 || ack1) early_ack = 1'b1;
            if (!clr_busy) break;
            busy_cycles++;
        end
        chk("clr_busy cycles", 32'(busy_cycles), 32'd4096);
        chk("ack during clear", 32'(early_ack), 32'd0);
        seen = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (ack0) begin
                seen = 1'b1;
                lat = n;
                break;
            end
        end
        req0 = 1'b0;
        chk("pending ack after clear", 32'(seen), 32'd1);
        chk("pending ack latency", 32'(lat), 32'd2);
        chk("cleared 4095", 32'(rdata0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            access0(1'b0, fill[i], 16'h0000, rd);
            chk($sformatf("cleared addr %h", fill[i]), 32'(rd), 32'd0);
        end

        // Reset 100 cycles into a clear: outputs drop at once, top word untouched.
        v = 16'h5A5A;
        access0(1'b1, 12'hFFF, v, rd);
        access0(1'b0, 12'hFFF, 16'h0000, rd);
        chk("pre-abort read", 32'(rd), 32'(v));
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (99) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async rst clr_busy", 32'(clr_busy), 32'd0);
        chk("async rst mem_load", 32'(mem_load), 32'd0);
        chk("async rst mem_address", 32'(mem_address), 32'd0);
        chk("async rst rdata0", 32'(rdata0), 32'd0);
        chk("async rst rdata1", 32'(rdata1), 32'd0);
        chk("async rst ack0", 32'(ack0), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post-reset clr_busy", 32'(clr_busy), 32'd0);
        access0(1'b0, 12'hFFF, 16'h0000, rd);
        chk("4095 survives abort", 32'(rd), 32'(v));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
